ad_tp_chk: RTL and testbench

- Checker at the receiving end of the AD test-pattern stream.
- Consumes the 24-bit sample/valid stream and verifies two properties:
  - the value sequence follows base + n*step (mod 2^24);
  - the spacing between valid strobes matches the sample-rate period selected by cfg_sample.
- Tracks lock state and counts samples, value errors and interval errors for register readback and the self-test path in ad_top.

---
 rtl/ad_tp_chk.sv | 215 +++++++++++++++++++++
 tb/tb_ad_tp_chk.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ad_tp_chk.sv
// Receive-side checker for the AD test-pattern stream: verifies base + n*step
// value progression and strobe spacing, tracks lock and keeps error statistics.
module ad_tp_chk #(
  parameter int unsigned SIM      = 0,
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned MISS_N   = 3,
  parameter int unsigned INTV_TOL = 0
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [23:0] ad_data,
  input  logic        ad_vld,
  input  logic [7:0]  cfg_sample,
  input  logic        cfg_chk_en,
  input  logic        cfg_chk_mode,
  input  logic [23:0] cfg_tp_base,
  input  logic [7:0]  cfg_tp_step,
  input  logic        cnt_clr,
  output logic        chk_lock,
  output logic        chk_err,
  output logic [15:0] err_cnt,
  output logic [15:0] intv_err_cnt,
  output logic [31:0] smp_cnt
);

  localparam int unsigned DW   = 24;
  localparam int unsigned RUNW = 4;
  localparam logic [RUNW-1:0] LOCK_NW = RUNW'(LOCK_N);
  localparam logic [RUNW-1:0] MISS_NW = RUNW'(MISS_N);
  localparam logic [DW+1:0]   TOL_W   = (DW+2)'(INTV_TOL);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_VERIFY, S_LOCK} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_exp;
  logic [RUNW-1:0] r_run;
  logic [RUNW-1:0] r_miss;
  logic [DW-1:0]   r_intv;
  logic [DW-1:0]   r_base_q;
  logic [7:0]      r_step_q;
  logic [7:0]      r_sample_q;
  logic            r_chk_lock;
  logic            r_chk_err;
  logic [15:0]     r_err_cnt;
  logic [15:0]     r_intv_err_cnt;
  logic [31:0]     r_smp_cnt;

  logic [DW-1:0]   w_period;
  logic [DW-1:0]   w_tmo_lim;
  logic [DW-1:0]   w_step;
  logic [DW-1:0]   w_next_exp;
  logic [DW:0]     w_intv;
  logic            w_intv_bad;
  logic            w_cfg_chg;
  logic            w_match;
  logic            w_seed_ok;
  logic            w_active;
  logic            w_tmo;
  logic            w_lock_vld;
  logic            w_val_err;
  logic            w_int_err;
  logic            w_smp;

  // Nominal strobe period in clk_sys cycles for a rate code
  function automatic logic [DW-1:0] period_of(input logic [7:0] code);
    case (code)
      8'd20:   return (SIM != 0) ? DW'(50)   : DW'(50_000);
      8'd10:   return (SIM != 0) ? DW'(100)  : DW'(100_000);
      8'd5:    return (SIM != 0) ? DW'(200)  : DW'(200_000);
      8'd2:    return (SIM != 0) ? DW'(500)  : DW'(500_000);
      8'd1:    return (SIM != 0) ? DW'(1000) : DW'(1_000_000);
      default: return DW'(100_000);
    endcase
  endfunction

  assign w_period   = period_of(cfg_sample);
  assign w_tmo_lim  = (w_period << 1) - DW'(1);
  assign w_step     = DW'(cfg_tp_step);
  assign w_next_exp = ad_data + w_step;
  assign w_intv     = {1'b0, r_intv} + (DW+1)'(1);
  assign w_intv_bad = (((DW+2)'(w_intv) + TOL_W) < (DW+2)'(w_period)) ||
                      ((DW+2)'(w_intv) > ((DW+2)'(w_period) + TOL_W));
  assign w_cfg_chg  = (cfg_tp_base != r_base_q) || (cfg_tp_step != r_step_q) ||
                      (cfg_sample != r_sample_q);
  assign w_match    = (ad_data == r_exp);
  assign w_seed_ok  = !cfg_chk_mode || (ad_data == cfg_tp_base);
  // Errors are suppressed while disabled and in the cycle a config change is seen
  assign w_active   = cfg_chk_en && !w_cfg_chg;
  assign w_tmo      = (r_state == S_LOCK) && !ad_vld && (r_intv == w_tmo_lim);
  assign w_lock_vld = w_active && ad_vld && (r_state == S_LOCK);
  assign w_val_err  = w_lock_vld && !w_match;
  assign w_int_err  = (w_lock_vld && w_intv_bad) || (w_active && w_tmo);
  assign w_smp      = cfg_chk_en && ad_vld;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_intv     <= '0;
      r_base_q   <= '0;
      r_step_q   <= '0;
      r_sample_q <= '0;
    end else begin
      r_base_q   <= cfg_tp_base;
      r_step_q   <= cfg_tp_step;
      r_sample_q <= cfg_sample;
      if (ad_vld)            r_intv <= '0;
      else if (r_intv != '1) r_intv <= r_intv + DW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_exp      <= '0;
      r_run      <= '0;
      r_miss     <= '0;
      r_chk_lock <= 1'b0;
      r_chk_err  <= 1'b0;
    end else begin
      r_chk_err <= w_val_err || w_int_err;
      if (!cfg_chk_en) begin
        r_state    <= S_IDLE;
        r_run      <= '0;
        r_miss     <= '0;
        r_chk_lock <= 1'b0;
      end else if (w_cfg_chg) begin
        r_state    <= S_SEEK;
        r_run      <= '0;
        r_miss     <= '0;
        r_chk_lock <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_SEEK;
          S_SEEK: begin
            if (ad_vld && w_seed_ok) begin
              r_exp <= w_next_exp;
              r_run <= RUNW'(1);
              if (LOCK_NW <= RUNW'(1)) begin
                r_state    <= S_LOCK;
                r_miss     <= '0;
                r_chk_lock <= 1'b1;
              end else begin
                r_state <= S_VERIFY;
              end
            end
          end
          S_VERIFY: begin
            if (ad_vld) begin
              if (w_match) begin
                r_exp <= w_next_exp;
                r_run <= r_run + RUNW'(1);
                if ((r_run + RUNW'(1)) >= LOCK_NW) begin
                  r_state    <= S_LOCK;
                  r_miss     <= '0;
                  r_chk_lock <= 1'b1;
                end
              end else if (!cfg_chk_mode) begin
                r_exp <= w_next_exp;
                r_run <= RUNW'(1);
              end else begin
                r_state <= S_SEEK;
                r_run   <= '0;
              end
            end
          end
          S_LOCK: begin
            if (w_tmo) begin
              r_state    <= S_SEEK;
              r_run      <= '0;
              r_miss     <= '0;
              r_chk_lock <= 1'b0;
            end else if (ad_vld) begin
              // Always resync to the received value so one glitch costs one error
              r_exp <= w_next_exp;
              if (w_match) begin
                r_miss <= '0;
              end else if ((r_miss + RUNW'(1)) >= MISS_NW) begin
                r_state    <= S_SEEK;
                r_run      <= '0;
                r_miss     <= '0;
                r_chk_lock <= 1'b0;
              end else begin
                r_miss <= r_miss + RUNW'(1);
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Saturating statistics; a clear coinciding with an event leaves a count of one
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_err_cnt      <= '0;
      r_intv_err_cnt <= '0;
      r_smp_cnt      <= '0;
    end else if (cnt_clr) begin
      r_err_cnt      <= 16'(w_val_err);
      r_intv_err_cnt <= 16'(w_int_err);
      r_smp_cnt      <= 32'(w_smp);
    end else begin
      if (w_val_err && (r_err_cnt != '1))      r_err_cnt      <= r_err_cnt + 16'd1;
      if (w_int_err && (r_intv_err_cnt != '1)) r_intv_err_cnt <= r_intv_err_cnt + 16'd1;
      if (w_smp && (r_smp_cnt != '1))          r_smp_cnt      <= r_smp_cnt + 32'd1;
    end
  end

  assign chk_lock     = r_chk_lock;
  assign chk_err      = r_chk_err;
  assign err_cnt      = r_err_cnt;
  assign intv_err_cnt = r_intv_err_cnt;
  assign smp_cnt      = r_smp_cnt;

endmodule

// File: tb/tb_ad_tp_chk.sv
// Directed bench for ad_tp_chk (simulation period table, rate code 10 -> 100 cycles).
module tb_ad_tp_chk;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [23:0] ad_data;
  logic        ad_vld;
  logic [7:0]  cfg_sample;
  logic        cfg_chk_en;
  logic        cfg_chk_mode;
  logic [23:0] cfg_tp_base;
  logic [7:0]  cfg_tp_step;
  logic        cnt_clr;
  logic        chk_lock;
  logic        chk_err;
  logic [15:0] err_cnt;
  logic [15:0] intv_err_cnt;
  logic [31:0] smp_cnt;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_puls = 0;
  logic s_lock;
  logic s_err;

  ad_tp_chk #(.SIM(1), .LOCK_N(4), .MISS_N(3), .INTV_TOL(0)) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .ad_data      (ad_data),
    .ad_vld       (ad_vld),
    .cfg_sample   (cfg_sample),
    .cfg_chk_en   (cfg_chk_en),
    .cfg_chk_mode (cfg_chk_mode),
    .cfg_tp_base  (cfg_tp_base),
    .cfg_tp_step  (cfg_tp_step),
    .cnt_clr      (cnt_clr),
    .chk_lock     (chk_lock),
    .chk_err      (chk_err),
    .err_cnt      (err_cnt),
    .intv_err_cnt (intv_err_cnt),
    .smp_cnt      (smp_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (chk_err === 1'b1) n_puls++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // One-cycle strobe; next strobe (if any) is sampled sp edges later
  task automatic send(input logic [23:0] d, input int sp, input bit clr_co);
    ad_data = d;
    ad_vld  = 1'b1;
    cnt_clr = clr_co;
    @(posedge clk_sys);
    #1;
    ad_vld  = 1'b0;
    cnt_clr = 1'b0;
    s_lock  = chk_lock;
    s_err   = chk_err;
    wait_n(sp - 1);
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    wait_n(1);
    cnt_clr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1; ad_data = '0; ad_vld = 1'b0; cnt_clr = 1'b0;
    cfg_sample = 8'd10; cfg_chk_en = 1'b1; cfg_chk_mode = 1'b0;
    cfg_tp_base = 24'h000100; cfg_tp_step = 8'd3;
    wait_n(3);
    check_eq("rst_lock", 32'(chk_lock), 32'd0);
    check_eq("rst_err", 32'(chk_err), 32'd0);
    check_eq("rst_errcnt", 32'(err_cnt), 32'd0);
    check_eq("rst_smpcnt", smp_cnt, 32'd0);
    rst = 1'b0;
    wait_n(3);

    // Lock acquisition: lock visible right after the 4th strobe
    for (int k = 0; k < 4; k++) begin
      send(24'(24'h100 + 3 * k), 100, 1'b0);
      if (k == 2) check_eq("lock_after3", 32'(s_lock), 32'd0);
    end
    check_eq("lock_after4", 32'(s_lock), 32'd1);
    for (int k = 4; k < 20; k++) send(24'(24'h100 + 3 * k), 100, 1'b0);
    check_eq("smp_20", smp_cnt, 32'd20);
    check_eq("err_0", 32'(err_cnt), 32'd0);
    check_eq("intv_0", 32'(intv_err_cnt), 32'd0);

    // Single corrupted sample (expected 0x13C) then resync
    p0 = n_puls;
    send(24'h000200, 100, 1'b0);
    check_eq("bad1_pulse", 32'(s_err), 32'd1);
    check_eq("bad1_errcnt", 32'(err_cnt), 32'd1);
    send(24'h000203, 50, 1'b0);
    check_eq("resync_noerr", 32'(s_err), 32'd0);
    check_eq("resync_lock", 32'(s_lock), 32'd1);
    check_eq("bad1_npulse", 32'(n_puls - p0), 32'd1);
    pulse_clr();
    wait_n(49);
    check_eq("clr_errcnt", 32'(err_cnt), 32'd0);
    check_eq("clr_smpcnt", smp_cnt, 32'd0);

    // Three consecutive bad values drop lock, clean data relocks after 4
    send(24'h000500, 100, 1'b0);
    check_eq("miss1_lock", 32'(s_lock), 32'd1);
    send(24'h000600, 100, 1'b0);
    send(24'h000700, 100, 1'b0);
    check_eq("miss3_lock", 32'(s_lock), 32'd0);
    check_eq("miss3_errcnt", 32'(err_cnt), 32'd3);
    send(24'h000800, 100, 1'b0);
    send(24'h000803, 100, 1'b0);
    send(24'h000806, 100, 1'b0);
    check_eq("relock3", 32'(s_lock), 32'd0);
    send(24'h000809, 101, 1'b0);
    check_eq("relock4", 32'(s_lock), 32'd1);

    // Interval 101 -> interval error with lock kept; then starve to timeout
    send(24'h00080C, 150, 1'b0);
    check_eq("intv101_pulse", 32'(s_err), 32'd1);
    check_eq("intv101_cnt", 32'(intv_err_cnt), 32'd1);
    check_eq("intv101_errcnt", 32'(err_cnt), 32'd3);
    check_eq("pre_tmo_lock", 32'(chk_lock), 32'd1);
    wait_n(60);
    check_eq("tmo_cnt", 32'(intv_err_cnt), 32'd2);
    check_eq("tmo_lock", 32'(chk_lock), 32'd0);

    // Wrap through zero
    cfg_tp_base = 24'hFFFFFD; cfg_tp_step = 8'd1;
    wait_n(2);
    pulse_clr();
    send(24'hFFFFFD, 100, 1'b0);
    send(24'hFFFFFE, 100, 1'b0);
    send(24'hFFFFFF, 100, 1'b0);
    send(24'h000000, 100, 1'b0);
    check_eq("wrap_lock", 32'(s_lock), 32'd1);
    send(24'h000001, 100, 1'b0);
    send(24'h000002, 100, 1'b0);
    check_eq("wrap_errcnt", 32'(err_cnt), 32'd0);
    check_eq("wrap_intv", 32'(intv_err_cnt), 32'd0);

    // Step change mid-stream drops lock with no error
    cfg_tp_step = 8'd2;
    wait_n(1);
    check_eq("cfgchg_lock", 32'(chk_lock), 32'd0);
    check_eq("cfgchg_err", 32'(chk_err), 32'd0);
    check_eq("cfgchg_errcnt", 32'(err_cnt), 32'd0);

    // Clear coincident with a value error leaves err_cnt at 1
    send(24'h000010, 100, 1'b0);
    send(24'h000012, 100, 1'b0);
    send(24'h000014, 100, 1'b0);
    send(24'h000016, 100, 1'b0);
    send(24'h000050, 100, 1'b0);
    check_eq("pre_clr_errcnt", 32'(err_cnt), 32'd1);
    send(24'h000090, 100, 1'b1);
    check_eq("clr_co_errcnt", 32'(err_cnt), 32'd1);
    check_eq("clr_co_smpcnt", smp_cnt, 32'd1);
    check_eq("clr_co_lock", 32'(s_lock), 32'd1);
    send(24'h000092, 30, 1'b0);

    // Reset mid-LOCK, with a bad strobe in the same cycle
    ad_data = 24'h000123; ad_vld = 1'b1; rst = 1'b1;
    wait_n(1);
    ad_vld = 1'b0;
    check_eq("rstmid_lock", 32'(chk_lock), 32'd0);
    check_eq("rstmid_err", 32'(chk_err), 32'd0);
    check_eq("rstmid_errcnt", 32'(err_cnt), 32'd0);
    check_eq("rstmid_smpcnt", smp_cnt, 32'd0);

    // Mode 1: wait for the base value before verifying
    cfg_chk_mode = 1'b1; cfg_tp_base = 24'h000040; cfg_tp_step = 8'd1;
    wait_n(1);
    rst = 1'b0;
    wait_n(3);
    for (int k = 1; k <= 5; k++) send(24'(24'h40 + k), 20, 1'b0);
    check_eq("m1_nobase_lock", 32'(s_lock), 32'd0);
    for (int k = 0; k < 4; k++) begin
      send(24'(24'h40 + k), 100, 1'b0);
      if (k == 2) check_eq("m1_lock3", 32'(s_lock), 32'd0);
    end
    check_eq("m1_lock4", 32'(s_lock), 32'd1);
    check_eq("m1_errcnt", 32'(err_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
